// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: issues a req/ack data-bus transaction for the core's loads and stores.
// Optional LSU_MISALIGN_CHECK_EN: misaligned half/word accesses skip the bus and pulse misalign.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] alu_result,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              stall,
  output logic              misalign,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_wstrb,
  input  logic              dbus_ack,
  input  logic [31:0]       dbus_rdata,
  output logic [1:0]        fsm_state
);

  // Handshake: dbus_req rises on REQ entry and holds, with all bus outputs stable,
  // through the cycle in which dbus_ack is sampled high; dbus_ack is ignored outside REQ.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_t;

  state_t      state;
  logic [1:0]  addr_lo_q;
  logic [2:0]  f3_q;
  logic        write_q;
  logic        access;
  logic        skip_req;
  logic [3:0]  strb_next;
  logic [31:0] wdata_next;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ext_data;

  assign access    = mem_read | mem_write;
  assign stall     = ((state == IDLE) && access) || (state == REQ);
  assign fsm_state = state;

  always_comb begin
    strb_next  = 4'b0000;
    wdata_next = store_data;
    if (funct3[1]) begin
      strb_next  = 4'b1111;
      wdata_next = store_data;
    end else if (funct3[0]) begin
      strb_next  = 4'b0011 << {alu_result[1], 1'b0};
      wdata_next = {2{store_data[15:0]}};
    end else begin
      strb_next  = 4'b0001 << alu_result[1:0];
      wdata_next = {4{store_data[7:0]}};
    end
    if (!mem_write) strb_next = 4'b0000;
  end

  // Lane select and extension of the returned word, using the latched address/funct3.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_q)
      2'd0:    byte_sel = dbus_rdata[7:0];
      2'd1:    byte_sel = dbus_rdata[15:8];
      2'd2:    byte_sel = dbus_rdata[23:16];
      default: byte_sel = dbus_rdata[31:24];
    endcase
    half_sel = addr_lo_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    if (f3_q[1])
      ext_data = dbus_rdata;
    else if (f3_q[0])
      ext_data = f3_q[2] ? {16'h0000, half_sel} : {{16{half_sel[15]}}, half_sel};
    else
      ext_data = f3_q[2] ? {24'h000000, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign skip_req = funct3[1] ? (alu_result[1:0] != 2'b00) : (funct3[0] & alu_result[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign <= 1'b0;
    else        misalign <= (state == IDLE) && access && skip_req;
  end
`else
  assign skip_req = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      addr_lo_q  <= 2'b00;
      f3_q       <= 3'b000;
      write_q    <= 1'b0;
      load_data  <= 32'h0;
      load_valid <= 1'b0;
      dbus_req   <= 1'b0;
      dbus_we    <= 1'b0;
      dbus_addr  <= '0;
      dbus_wdata <= 32'h0;
      dbus_wstrb <= 4'b0000;
    end else begin
      load_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            addr_lo_q <= alu_result[1:0];
            f3_q      <= funct3;
            write_q   <= mem_write;
            if (skip_req) begin
              state <= DONE;
            end else begin
              state      <= REQ;
              dbus_req   <= 1'b1;
              dbus_we    <= mem_write;
              dbus_addr  <= {alu_result[ADDR_W-1:2], 2'b00};
              dbus_wdata <= wdata_next;
              dbus_wstrb <= strb_next;
            end
          end
        end
        REQ: begin
          if (dbus_ack) begin
            state      <= DONE;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_wstrb <= 4'b0000;
            if (!write_q) begin
              load_data  <= ext_data;
              load_valid <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset/stray-ack sequences, randomized accesses vs a model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [31:0] load_data;
  logic        load_valid;
  logic        stall;
  logic        misalign;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ack = 1'b0;
  logic [31:0] dbus_rdata = 32'h0;
  logic [1:0]  fsm_state;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_ld_q = 32'h0;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .alu_result(alu_result), .store_data(store_data),
    .load_data(load_data), .load_valid(load_valid), .stall(stall), .misalign(misalign),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_wstrb(dbus_wstrb), .dbus_ack(dbus_ack),
    .dbus_rdata(dbus_rdata), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model written from the access rules with plain arithmetic.
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int unsigned off = addr % 4;
    logic [31:0] v;
    if (f3[1:0] == 2'b00) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (!f3[2] && v >= 128) v = v + 32'hFFFFFF00;
    end else if (f3[1:0] == 2'b01) begin
      v = (rd >> (16 * (off / 2))) & 32'hFFFF;
      if (!f3[2] && v >= 32768) v = v + 32'hFFFF0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_strb(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned off = addr % 4;
    int unsigned s;
    if (f3[1]) s = 15;
    else if (f3[0]) s = 3 << (2 * (off / 2));
    else s = 1 << off;
    return s[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
    if (f3[1]) return sd;
    else if (f3[0]) return (sd & 32'hFFFF) * 32'h00010001;
    else return (sd & 32'hFF) * 32'h01010101;
  endfunction

  function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef LSU_MISALIGN_CHECK_EN
    if (f3[1]) return (addr % 4) != 0;
    else if (f3[0]) return (addr % 2) != 0;
    else return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // One complete access; ack held high through DONE to show a stray ack there is ignored.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input int waits, input logic [31:0] rdata,
                            input logic [31:0] exp_ld, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata);
    bit mis;
    mis = model_mis(f3, addr);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; alu_result = addr; store_data = sd;
    #1;
    check("stall_issue", {31'b0, stall}, 32'd1);
    @(negedge clk);
    mem_read = 1'b0; mem_write = 1'b0;
    if (mis) begin
      check("mis_pulse", {31'b0, misalign}, 32'd1);
      check("mis_no_req", {31'b0, dbus_req}, 32'd0);
      check("mis_no_valid", {31'b0, load_valid}, 32'd0);
      check("mis_stall", {31'b0, stall}, 32'd0);
      check("mis_ld_hold", load_data, exp_ld_q);
      @(negedge clk);
      check("mis_clear", {31'b0, misalign}, 32'd0);
      check("mis_idle", {30'b0, fsm_state}, 32'd0);
      return;
    end
    check("req_state", {30'b0, fsm_state}, 32'd1);
    check("req_high", {31'b0, dbus_req}, 32'd1);
    check("req_we", {31'b0, dbus_we}, {31'b0, wr});
    check("req_addr", dbus_addr, addr & 32'hFFFFFFFC);
    check("req_wstrb", {28'b0, dbus_wstrb}, wr ? {28'b0, exp_strb} : 32'd0);
    if (wr) check("req_wdata", dbus_wdata, exp_wdata);
    check("req_stall", {31'b0, stall}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check("wait_req", {31'b0, dbus_req}, 32'd1);
      check("wait_addr", dbus_addr, addr & 32'hFFFFFFFC);
      check("wait_stall", {31'b0, stall}, 32'd1);
      check("wait_no_valid", {31'b0, load_valid}, 32'd0);
    end
    dbus_ack = 1'b1; dbus_rdata = rdata;
    @(negedge clk);
    if (!wr) exp_ld_q = exp_ld;
    check("done_state", {30'b0, fsm_state}, 32'd2);
    check("done_req", {31'b0, dbus_req}, 32'd0);
    check("done_stall", {31'b0, stall}, 32'd0);
    check("done_valid", {31'b0, load_valid}, {31'b0, !wr});
    check("done_misalign", {31'b0, misalign}, 32'd0);
    check("done_data", load_data, exp_ld_q);
    @(negedge clk);
    dbus_ack = 1'b0;
    check("idle_state", {30'b0, fsm_state}, 32'd0);
    check("idle_valid", {31'b0, load_valid}, 32'd0);
    check("idle_req", {31'b0, dbus_req}, 32'd0);
    check("idle_data", load_data, exp_ld_q);
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    int          waits;
    logic [31:0] rdata;
    logic [31:0] exp_ld;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1, 0, 3'b010, 32'h100, 32'h0,        0, 32'hDEADBEEF, 32'hDEADBEEF, 4'b0000, 32'h0};
    vecs[1] = '{0, 1, 3'b000, 32'h103, 32'h000000A5, 3, 32'h0,        32'h0,        4'b1000, 32'hA5A5A5A5};
    vecs[2] = '{1, 0, 3'b000, 32'h102, 32'h0,        0, 32'h00800000, 32'hFFFFFF80, 4'b0000, 32'h0};
    vecs[3] = '{1, 0, 3'b100, 32'h102, 32'h0,        1, 32'h00800000, 32'h00000080, 4'b0000, 32'h0};
    vecs[4] = '{0, 1, 3'b001, 32'h102, 32'h1234BEEF, 0, 32'h0,        32'h0,        4'b1100, 32'hBEEFBEEF};
    vecs[5] = '{1, 0, 3'b101, 32'h100, 32'h0,        2, 32'h80017FFE, 32'h00007FFE, 4'b0000, 32'h0};
    vecs[6] = '{1, 0, 3'b001, 32'h102, 32'h0,        0, 32'h80017FFE, 32'hFFFF8001, 4'b0000, 32'h0};
    vecs[7] = '{1, 1, 3'b010, 32'h200, 32'h11223344, 1, 32'h0,        32'h0,        4'b1111, 32'h11223344};
    vecs[8] = '{1, 0, 3'b001, 32'h101, 32'h0,        0, 32'h12348765, 32'hFFFF8765, 4'b0000, 32'h0};
    vecs[9] = '{1, 0, 3'b000, 32'h101, 32'h0,        0, 32'h00007F00, 32'h0000007F, 4'b0000, 32'h0};

    // Reset state
    @(negedge clk);
    check("rst_req", {31'b0, dbus_req}, 32'd0);
    check("rst_ld", load_data, 32'h0);
    check("rst_valid", {31'b0, load_valid}, 32'd0);
    check("rst_addr", dbus_addr, 32'h0);
    check("rst_wdata", dbus_wdata, 32'h0);
    check("rst_wstrb", {28'b0, dbus_wstrb}, 32'd0);
    check("rst_we", {31'b0, dbus_we}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 10; i++)
      run_access(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].sd, vecs[i].waits,
                 vecs[i].rdata, vecs[i].exp_ld, vecs[i].exp_strb, vecs[i].exp_wdata);

    // Stray ack while idle
    @(negedge clk);
    dbus_ack = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("stray_state", {30'b0, fsm_state}, 32'd0);
      check("stray_valid", {31'b0, load_valid}, 32'd0);
      check("stray_req", {31'b0, dbus_req}, 32'd0);
    end
    dbus_ack = 1'b0;

    // Reset asserted while a request is outstanding
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h340;
    @(negedge clk);
    mem_read = 1'b0;
    check("abort_req_before", {31'b0, dbus_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_req", {31'b0, dbus_req}, 32'd0);
    check("abort_addr", dbus_addr, 32'h0);
    check("abort_state", {30'b0, fsm_state}, 32'd0);
    check("abort_stall", {31'b0, stall}, 32'd0);
    check("abort_ld", load_data, 32'h0);
    exp_ld_q = 32'h0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_state", {30'b0, fsm_state}, 32'd0);
    check("post_rst_req", {31'b0, dbus_req}, 32'd0);

    // Randomized accesses checked against the model
    for (int i = 0; i < 60; i++) begin
      bit rd, wr;
      logic [2:0] f3;
      logic [31:0] addr, sd, rdata;
      int kind;
      kind = $urandom_range(0, 2);
      rd = (kind != 1);
      wr = (kind != 0);
      if (wr) f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: f3 = 3'b000;
          1: f3 = 3'b001;
          2: f3 = 3'b010;
          3: f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
      end
      addr = $urandom;
      sd = $urandom;
      rdata = $urandom;
      run_access(rd, wr, f3, addr, sd, $urandom_range(0, 3), rdata,
                 model_load(rdata, addr, f3), model_strb(f3, addr), model_wdata(f3, sd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the ALU and the register-file write-back mux of the single-cycle core. It takes the ALU result as the effective address and register-file read data 2 as store data. It runs a req/ack transaction on an external data bus and returns sign- or zero-extended load data. While a transaction is in flight it stalls the core so the PC and register-file write hold.

## Interface
- ADDR_W, 32, width of address input and data-bus address.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- mem_read  in  1  Memread from the main control unit.
- mem_write  in  1  Memwrite from the main control unit.
- funct3  in  3  instruction bits [14:12], selects access size and sign.
- alu_result  in  ADDR_W  effective address.
- store_data  in  32  rs2 value from the register file.
- load_data  out  32  extended load result to the MemtoReg mux.
- load_valid  out  1  one-cycle pulse when load_data is updated.
- stall  out  1  core must hold PC and suppress regwrite while 1.
- misalign  out  1  one-cycle pulse on misaligned access (present only with the macro; tied 0 otherwise).
- dbus_req  out  1  bus request, held until ack.
- dbus_we  out  1  1 = write.
- dbus_addr  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- dbus_wdata  out  32  lane-replicated store data.
- dbus_wstrb  out  4  byte enables, 0 on reads.
- dbus_ack  in  1  bus completion; sampled only in REQ.
- dbus_rdata  in  32  read word, valid in the ack cycle.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - mem_read or mem_write is 1 → latch address, funct3, store data and direction; go to REQ.
  - Both are 1 → treated as write.
- REQ:
  - dbus_req = 1.
  - dbus_ack = 1 → capture dbus_rdata for reads; go to DONE.
- DONE:
  - Inputs ignored.
  - Read: load_valid = 1.
  - Always go to IDLE next cycle.
- Sizes, by funct3[1:0]:
  - 00: byte.
  - 01: half.
  - 10 or 11: word.
- Extension: funct3[2] = 1 → zero-extend, 0 → sign-extend; ignored for word.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = 4'b0011 << {addr[1],1'b0}; wdata = {2{half}}.
  - SW: wstrb = 4'b1111.
- Load lanes: byte selected by latched addr[1:0]; half selected by addr[1].
- load_data holds its last value except in the DONE cycle of a read.

## Timing
- Reset values: state IDLE; load_data 0, load_valid 0, misalign 0, dbus_req 0, dbus_we 0, dbus_addr 0, dbus_wdata 0, dbus_wstrb 0.
- stall:
  - Combinational 1 in IDLE while mem_read|mem_write.
  - 1 throughout REQ.
  - 0 in DONE, so the PC advances on the DONE clock edge.
- Access seen in cycle N:
  - dbus_req rises at N+1.
  - Ack sampled in cycle M ≥ N+1.
  - DONE at M+1; load_data and load_valid are registered outputs in that cycle.
- Minimum latency is 2 cycles from access to load_valid (ack at N+1).
- Bus outputs are registered and stable from REQ entry until the ack cycle inclusive.
- dbus_ack outside REQ has no effect.
- reset low mid-transaction: dbus_req drops asynchronously and the transaction is abandoned. The bus must tolerate this.

## Configuration
- LSU_MISALIGN_CHECK_EN defined:
  - Misaligned cases: half with addr[0] = 1; word with addr[1:0] ≠ 0.
  - Such an access skips REQ: IDLE → DONE with misalign = 1 for one cycle.
  - No bus activity; load_valid = 0; load_data unchanged.
- Macro undefined:
  - misalign is tied 0.
  - Low address bits are ignored beyond lane selection; misaligned half and word accesses act as aligned to the containing half or word.

## Test plan
- Reset low with dbus_req high → all outputs 0 immediately; after release, FSM in IDLE with no req.
- LW at 0x100, ack on first REQ cycle, rdata 0xDEADBEEF → dbus_addr 0x100, wstrb 0, load_data 0xDEADBEEF, load_valid at N+2, stall high for N and N+1 only.
- SB at 0x103, store_data 0x000000A5, ack after 3 wait cycles → wstrb 4'b1000, wdata 0xA5A5A5A5, dbus_we 1, stall high until ack cycle, no load_valid.
- LB at 0x102 and LBU at 0x102, rdata 0x00800000 → load_data 0xFFFFFF80, then 0x00000080.
- LH at 0x101 with macro defined → misalign pulse, no dbus_req, stall high one cycle. Without macro → dbus_addr 0x100, low half extended.
- Stray dbus_ack in IDLE and DONE → no state change, no load_valid.
